ps2_rx_codes: RTL and testbench
===============================

Name: ps2_rx_codes

Overview:
- Next-generation PS/2 keyboard receiver; fully synchronous to clk (PS/2 lines are sampled, never used as clocks).
- Receives 11-bit device-to-host frames and checks odd parity and the stop bit.
- Assembles multi-byte scan codes (E0/F0/E1 prefixes) up to CODE_BYTES long and queues completed codes in a FIFO with a valid/ready interface.
- Sits between the board PS/2 pins and the display/control logic.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on ps2_clk and ps2_dat; minimum 2.
- TIMEOUT_CYC, 50000: clk cycles without a PS/2 falling edge before an in-progress frame is aborted.
- CODE_BYTES, 4: maximum bytes per assembled code; minimum 3.
- FIFO_DEPTH, 4: number of queued codes; power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock line
- ps2_dat  in  1  raw PS/2 data line
- code_data  out  8*CODE_BYTES  head code; newest byte in [7:0]; zero-extended
- code_len  out  $clog2(CODE_BYTES+1)  byte count of head code
- code_break  out  1  head code contains an F0 byte
- code_valid  out  1  FIFO non-empty
- code_ready  in  1  consumer accepts head when code_valid=1
- err_parity  out  1  1-cycle pulse: parity error
- err_frame  out  1  1-cycle pulse: bad stop bit or timeout
- overflow  out  1  1-cycle pulse: completed code dropped because FIFO full

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clk is the only clock. Reset clears all state and outputs: code_data=0, code_len=0, code_break=0, code_valid=0, all pulse outputs=0. FIFO is emptied and the FSM goes to IDLE. Reset mid-frame discards the frame silently.
- Edge detect: after the SYNC_STAGES synchroniser, a PS/2 falling edge is detected when the synchronised clock is 0 now and was 1 in the previous cycle. All sampling of ps2_dat (synchronised) happens on that cycle.
- Frame FSM, IDLE -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: edge with dat=0 -> DATA and clear the bit counter; edge with dat=1 is ignored.
  - DATA: shift in 8 bits, LSB first; after the 8th bit -> PARITY.
  - PARITY: latch the bit -> STOP.
  - STOP: evaluate the frame -> IDLE.
    - Parity good when XOR(data, parity)=1.
    - Parity bad -> err_parity pulse.
    - Parity good but stop=0 -> err_frame pulse.
    - Any error: byte dropped and partial code cleared.
- Timeout: a counter is cleared on every edge and increments otherwise. In any state other than IDLE, reaching TIMEOUT_CYC-1 -> IDLE, err_frame pulse, partial code cleared. The counter saturates in IDLE.
- Code assembly, applied to each good byte b:
  - The byte is appended: code = (code<<8)|b and len = len+1.
  - Special-byte rules:
    - If an E1 count is pending, decrement it; the code completes when the count reaches 0.
    - Otherwise b=E1 sets the pending count to 2.
    - Otherwise b=E0 or b=F0 means the code continues.
    - Otherwise the code is complete.
  - If len reaches CODE_BYTES, the code completes regardless of the rules above.
  - Resulting sequences: Pause yields E11477, E1F014, F077. Release of extended key 7C yields E0F07C.
- Timing:
  - The good stop bit is sampled in cycle N; the FIFO write happens in N+1.
  - code_valid goes high in N+2 if the FIFO was empty.
  - After a completed code, the assembler restarts at len=0 with break cleared.
- FIFO behaviour:
  - Show-ahead: code_data/len/break always reflect the head.
  - Pop when code_valid&code_ready.
  - Push while full without a same-cycle pop: code dropped, overflow pulse.
  - Push while full with a same-cycle pop: accepted.
  - Pointers wrap modulo FIFO_DEPTH.
  - When empty, outputs hold their last values and code_valid=0.

Optional Feature:
- Macro: PS2_ERR_CODE_EN.
- With it defined: every err_parity/err_frame event also pushes a sentinel entry with code_data all-0xEE bytes (CODE_BYTES of them), code_len=0 and code_break=0. The sentinel follows the same full/overflow rules as a normal code.
- Without it: errors produce pulses only and nothing is queued.

Test Plan (SYNC_STAGES=2, TIMEOUT_CYC=200, PS/2 bit period 20 clk):
- Single key: frame 0x1C with parity 0, stop 1, code_ready=1 -> one entry: code_data=0x1C, len=1, break=0; valid rises 2 clk after the stop edge.
- Extended release: bytes E0,F0,7C -> one entry 0x00E0F07C, len=3, break=1; nothing is pushed after E0 or F0 alone.
- Pause: E1 14 77 E1 F0 14 F0 77 -> three entries, in order: E11477 (len 3), E1F014 (len 3, break 1), F077 (len 2, break 1).
- Parity error: frame 0x1C sent with parity 1 -> err_parity pulse, no entry. Next good 0x1C -> entry 0x1C. With PS2_ERR_CODE_EN: sentinel 0xEEEEEEEE, len 0, queued first.
- Timeout: clock stopped after 4 data bits for 250 clk -> err_frame pulse, FSM in IDLE; next full frame 0x1C is received correctly.
- Overflow: code_ready=0, send 5 single-byte codes 0x01..0x05 -> FIFO holds 01..04, one overflow pulse on 05; raising code_ready drains 01,02,03,04 in order, then valid=0.

Source files
------------

// File: rtl/ps2_rx_codes.sv
// PS/2 keyboard receiver: synchronised frame decoder, multi-byte scan-code assembler and code FIFO.
// Define PS2_ERR_CODE_EN to also queue an all-0xEE sentinel code on every parity/frame error.
module ps2_rx_codes #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned CODE_BYTES  = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ps2_clk_i,
  input  logic                               ps2_dat_i,
  output logic [8*CODE_BYTES-1:0]            code_data_o,
  output logic [$clog2(CODE_BYTES+1)-1:0]    code_len_o,
  output logic                               code_break_o,
  output logic                               code_valid_o,
  input  logic                               code_ready_i,
  output logic                               err_parity_o,
  output logic                               err_frame_o,
  output logic                               overflow_o
);
  localparam int unsigned CodeW = 8 * CODE_BYTES;
  localparam int unsigned LenW  = $clog2(CODE_BYTES + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam logic [TmoW-1:0]  TmoMax   = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [CodeW-1:0] Sentinel = {CODE_BYTES{8'hEE}};

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, dat_s, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              par_q;
  logic [TmoW-1:0]   tmo_q;
  // Partial code never exceeds CODE_BYTES-1 bytes; the last byte completes it.
  logic [CodeW-9:0]  code_q;
  logic [LenW-1:0]   len_q;
  logic              brk_q;
  logic [1:0]        e1_q;
  logic              push_q, push_brk_q, perr_q, ferr_q;
  logic [CodeW-1:0]  push_data_q;
  logic [LenW-1:0]   push_len_q;

  logic              tmo_hit, stop_evt, par_err, frm_err, good;
  logic [CodeW-1:0]  asm_code;
  logic [LenW-1:0]   asm_len;
  logic              asm_brk, asm_done;
  logic [1:0]        asm_e1;

  always_comb begin
    tmo_hit  = (state_q != StIdle) && !fall && (tmo_q == TmoMax);
    stop_evt = fall && (state_q == StStop);
    par_err  = stop_evt && !(^{shift_q, par_q});
    frm_err  = tmo_hit || (stop_evt && (^{shift_q, par_q}) && !dat_s);
    good     = stop_evt && (^{shift_q, par_q}) && dat_s;
    asm_code = {code_q, shift_q};
    asm_len  = len_q + LenW'(1);
    asm_brk  = brk_q | (shift_q == 8'hF0);
    asm_e1   = e1_q;
    asm_done = 1'b0;
    if (e1_q != 2'd0) begin
      asm_e1   = e1_q - 2'd1;
      asm_done = (e1_q == 2'd1);
    end else if (shift_q == 8'hE1) begin
      asm_e1 = 2'd2;
    end else if (shift_q != 8'hE0 && shift_q != 8'hF0) begin
      asm_done = 1'b1;
    end
    if (asm_len == LenW'(CODE_BYTES)) asm_done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      code_q      <= '0;
      len_q       <= '0;
      brk_q       <= 1'b0;
      e1_q        <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_len_q  <= '0;
      push_brk_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      push_q <= 1'b0;
      perr_q <= par_err;
      ferr_q <= frm_err;
      if (fall) tmo_q <= '0;
      else if (tmo_q != TmoMax) tmo_q <= tmo_q + TmoW'(1);

      if (tmo_hit) begin
        state_q <= StIdle;
      end else if (fall) begin
        unique case (state_q)
          StIdle: if (!dat_s) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
          end
          StData: begin
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            par_q   <= dat_s;
            state_q <= StStop;
          end
          StStop: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end

      if (par_err || frm_err) begin
        code_q <= '0;
        len_q  <= '0;
        brk_q  <= 1'b0;
        e1_q   <= '0;
`ifdef PS2_ERR_CODE_EN
        push_q      <= 1'b1;
        push_data_q <= Sentinel;
        push_len_q  <= '0;
        push_brk_q  <= 1'b0;
`endif
      end else if (good) begin
        if (asm_done) begin
          code_q      <= '0;
          len_q       <= '0;
          brk_q       <= 1'b0;
          e1_q        <= '0;
          push_q      <= 1'b1;
          push_data_q <= asm_code;
          push_len_q  <= asm_len;
          push_brk_q  <= asm_brk;
        end else begin
          code_q <= asm_code[CodeW-9:0];
          len_q  <= asm_len;
          brk_q  <= asm_brk;
          e1_q   <= asm_e1;
        end
      end
    end
  end

  logic [CodeW-1:0] mem_data_q [FIFO_DEPTH];
  logic [LenW-1:0]  mem_len_q  [FIFO_DEPTH];
  logic             mem_brk_q  [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q, wptr_d, rptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             full, pop, wr, hit, ovf_q;

  always_comb begin
    full   = (cnt_q == (PtrW+1)'(FIFO_DEPTH));
    pop    = (cnt_q != '0) && code_ready_i;
    wr     = push_q && (!full || pop);
    rptr_d = pop ? rptr_q + PtrW'(1) : rptr_q;
    wptr_d = wr ? wptr_q + PtrW'(1) : wptr_q;
    cnt_d  = cnt_q + (PtrW+1)'(wr) - (PtrW+1)'(pop);
    // The new head is the entry being written only when it lands in an otherwise empty FIFO.
    hit    = wr && (wptr_q == rptr_d);
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data_q[wptr_q] <= push_data_q;
      mem_len_q[wptr_q]  <= push_len_q;
      mem_brk_q[wptr_q]  <= push_brk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      code_data_o  <= '0;
      code_len_o   <= '0;
      code_break_o <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= push_q && full && !pop;
      if (cnt_d != '0) begin
        code_data_o  <= hit ? push_data_q : mem_data_q[rptr_d];
        code_len_o   <= hit ? push_len_q  : mem_len_q[rptr_d];
        code_break_o <= hit ? push_brk_q  : mem_brk_q[rptr_d];
      end
    end
  end

  assign code_valid_o = (cnt_q != '0);
  assign err_parity_o = perr_q;
  assign err_frame_o  = ferr_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_codes.sv
// Scoreboard bench for ps2_rx_codes: directed PS/2 frames, expected codes queued, monitor pops.
module tb_ps2_rx_codes;
  localparam int unsigned SyncStages = 2;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  l;
    logic        b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [31:0] code_data;
  logic [2:0]  code_len;
  logic        code_break, code_valid, err_parity, err_frame, overflow;
  logic        code_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int n_perr = 0, n_ferr = 0, n_ovf = 0;
  int cyc = 0;
  int stop_fall_cyc = -1;
  int valid_rise_cyc = -1;
  exp_t sb[$];

  ps2_rx_codes #(
    .SYNC_STAGES(SyncStages),
    .TIMEOUT_CYC(200),
    .CODE_BYTES (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .code_data_o (code_data),
    .code_len_o  (code_len),
    .code_break_o(code_break),
    .code_valid_o(code_valid),
    .code_ready_i(code_ready),
    .err_parity_o(err_parity),
    .err_frame_o (err_frame),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bits 0..nbits-1 of {stop, parity, data, start}; 20 clk per bit, clock low for 10.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      tick(5);
      ps2_clk = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      tick(10);
      ps2_clk = 1'b1;
      tick(5);
    end
    ps2_dat = 1'b1;
    tick(30);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1, 11);
  endtask

  task automatic expect_code(input logic [31:0] d, input logic [2:0] l, input logic b);
    exp_t e;
    e.d = d;
    e.l = l;
    e.b = b;
    sb.push_back(e);
  endtask

  task automatic expect_sentinel();
`ifdef PS2_ERR_CODE_EN
    expect_code(32'hEEEE_EEEE, 3'd0, 1'b0);
`endif
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      tick(1);
      t++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops on each accepted head and counts pulses.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_parity) n_perr++;
        if (err_frame) n_ferr++;
        if (overflow) n_ovf++;
        if (code_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = code_valid;
        if (code_valid && code_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL entry: got data=%0h len=%0d brk=%0b expected no entry",
                     code_data, code_len, code_break);
          end else begin
            e = sb.pop_front();
            if (code_data !== e.d || code_len !== e.l || code_break !== e.b) begin
              failures++;
              $display("FAIL entry: got data=%0h len=%0d brk=%0b expected data=%0h len=%0d brk=%0b",
                       code_data, code_len, code_break, e.d, e.l, e.b);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int perr0, ferr0, ovf0;
    tick(4);
    check("rst_valid", 64'(code_valid), 64'd0);
    check("rst_data", 64'(code_data), 64'd0);
    check("rst_len", 64'(code_len), 64'd0);
    check("rst_break", 64'(code_break), 64'd0);
    check("rst_pulses", 64'({err_parity, err_frame, overflow}), 64'd0);
    rst_n = 1'b1;
    tick(10);

    // Single key with latency from the stop-bit edge.
    expect_code(32'h1C, 3'd1, 1'b0);
    valid_rise_cyc = -1;
    send_byte(8'h1C);
    wait_drain("single_drain");
    check("single_latency", 64'(valid_rise_cyc - stop_fall_cyc), 64'(SyncStages + 2));

    // Extended release.
    expect_code(32'h00E0F07C, 3'd3, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h7C);
    wait_drain("ext_drain");

    // Pause sequence.
    expect_code(32'h00E11477, 3'd3, 1'b0);
    expect_code(32'h00E1F014, 3'd3, 1'b1);
    expect_code(32'h0000F077, 3'd2, 1'b1);
    foreach (sb[i]) begin end
    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    send_byte(8'h77);
    wait_drain("pause_drain");

    // Parity error, then a good frame.
    perr0 = n_perr;
    expect_sentinel();
    expect_code(32'h1C, 3'd1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    check("parity_pulse", 64'(n_perr - perr0), 64'd1);
    send_byte(8'h1C);
    wait_drain("parity_drain");

    // Bad stop bit aborts a partial code too.
    ferr0 = n_ferr;
    expect_sentinel();
    expect_code(32'h5A, 3'd1, 1'b0);
    send_byte(8'hE0);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check("stop_pulse", 64'(n_ferr - ferr0), 64'd1);
    send_byte(8'h5A);
    wait_drain("stop_drain");

    // Timeout after 4 data bits.
    ferr0 = n_ferr;
    expect_sentinel();
    expect_code(32'h1C, 3'd1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    tick(250);
    check("timeout_pulse", 64'(n_ferr - ferr0), 64'd1);
    send_byte(8'h1C);
    wait_drain("timeout_drain");

    // Overflow with consumer stalled.
    ovf0 = n_ovf;
    code_ready = 1'b0;
    for (int i = 1; i <= 4; i++) expect_code(32'(i), 3'd1, 1'b0);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check("ovf_pulse", 64'(n_ovf - ovf0), 64'd1);
    check("ovf_valid", 64'(code_valid), 64'd1);
    check("ovf_head", 64'(code_data), 64'h01);
    code_ready = 1'b1;
    wait_drain("ovf_drain");
    tick(3);
    check("ovf_empty", 64'(code_valid), 64'd0);
    check("ovf_hold", 64'(code_data), 64'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
